// File: rtl/window3x3_gen_if.sv
// ---------------------------------------------------------------------------
// window3x3_gen_if
// Stream bundle between the pixel source, window3x3_gen and the window sink.
//
// Signals:
//   in_valid   pixel present this cycle
//   in_sof     with in_valid: this pixel is (0,0) of a new frame
//   in_pixel   8-bit greyscale pixel
//   out_valid  3x3 window valid this cycle
//   out_win    72-bit window, w[r][c] = out_win[(r*3+c)*8 +: 8]
//   out_last   with out_valid: last window of the frame
//   out_x/out_y (only with WINDOW_COORD_EN) window centre coordinates
//
// Modports:
//   slave  - the window generator (consumes in_*, drives out_*)
//   master - the environment (drives in_*, consumes out_*)
//
// Optional feature macro: WINDOW_COORD_EN
// ---------------------------------------------------------------------------
interface window3x3_gen_if
`ifdef WINDOW_COORD_EN
    #(
        parameter int ADDR_BITS = 10,
        parameter int ROW_BITS  = 9
    )
`endif
    ();

    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_pixel;
    logic        out_valid;
    logic [71:0] out_win;
    logic        out_last;
`ifdef WINDOW_COORD_EN
    logic [ADDR_BITS-1:0] out_x;
    logic [ROW_BITS-1:0]  out_y;

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output out_valid, out_win, out_last, out_x, out_y
    );

    modport master (
        output in_valid, in_sof, in_pixel,
        input  out_valid, out_win, out_last, out_x, out_y
    );
`else
    modport slave (
        input  in_valid, in_sof, in_pixel,
        output out_valid, out_win, out_last
    );

    modport master (
        output in_valid, in_sof, in_pixel,
        input  out_valid, out_win, out_last
    );
`endif

endinterface

// File: rtl/window3x3_gen.sv
// ---------------------------------------------------------------------------
// window3x3_gen
// Turns a raster greyscale pixel stream into a stream of 3x3 neighbourhood
// windows for the gradient kernel. Two internal row stores hold the previous
// two rows (ram_a = row r-1, ram_b = row r-2); ram_a cascades into ram_b as
// each new row is written. Pixel-rate, no backpressure.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset (row-store contents are kept)
//   bus   window3x3_gen_if.slave: in_valid/in_sof/in_pixel in,
//         out_valid/out_win/out_last (and out_x/out_y) out
//
// Parameters: IMG_W, IMG_H (frame size), ADDR_BITS (2**ADDR_BITS >= IMG_W),
//             ROW_BITS (2**ROW_BITS >= IMG_H).
//
// Optional feature macro: WINDOW_COORD_EN - adds registered centre
// coordinates out_x/out_y on the interface.
//
// Timing: a pixel accepted at edge k is read against the row stores at k,
// lands in the window at k+1, and appears on out_win after edge k+1.
// ---------------------------------------------------------------------------
module window3x3_gen #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int ADDR_BITS = 10,
    parameter int ROW_BITS  = 9
) (
    input  logic            clk,
    input  logic            rst,
    window3x3_gen_if.slave  bus
);

    localparam int RAM_DEPTH = 2 ** ADDR_BITS;

    // Raster position counters (position of the next pixel)
    logic [ADDR_BITS-1:0] r_col;
    logic [ROW_BITS-1:0]  r_row;

    // Stage-1 pipeline registers
    logic                 r_v1;
    logic [7:0]           r_pix_d;
    logic [ADDR_BITS-1:0] r_col_d;
    logic [ROW_BITS-1:0]  r_row_d;

    // Row stores and their registered read data
    logic [7:0]           r_ram_a [0:RAM_DEPTH-1];
    logic [7:0]           r_ram_b [0:RAM_DEPTH-1];
    logic [7:0]           r_rd_a;
    logic [7:0]           r_rd_b;

    // Working window and output registers
    logic [71:0]          r_win;
    logic [71:0]          r_out_win;
    logic                 r_out_valid;
    logic                 r_out_last;
`ifdef WINDOW_COORD_EN
    logic [ADDR_BITS-1:0] r_out_x;
    logic [ROW_BITS-1:0]  r_out_y;
`endif

    // Combinational helpers
    logic [ADDR_BITS-1:0] w_col_cur;
    logic [ROW_BITS-1:0]  w_row_cur;
    logic [ADDR_BITS-1:0] w_col_nxt;
    logic [ROW_BITS-1:0]  w_row_nxt;
    logic [71:0]          w_win_nxt;
    logic                 w_emit;
    logic                 w_last;

    // Position of the incoming pixel (in_sof forces it to (0,0)) and the
    // position of the pixel after it, wrapping at the end of row and frame.
    always_comb begin
        w_col_cur = r_col;
        w_row_cur = r_row;
        if (bus.in_sof) begin
            w_col_cur = {ADDR_BITS{1'b0}};
            w_row_cur = {ROW_BITS{1'b0}};
        end else begin
            w_col_cur = r_col;
            w_row_cur = r_row;
        end

        w_col_nxt = w_col_cur + ADDR_BITS'(1);
        w_row_nxt = w_row_cur;
        if (w_col_cur == ADDR_BITS'(IMG_W - 1)) begin
            w_col_nxt = {ADDR_BITS{1'b0}};
            if (w_row_cur == ROW_BITS'(IMG_H - 1)) begin
                w_row_nxt = {ROW_BITS{1'b0}};
            end else begin
                w_row_nxt = w_row_cur + ROW_BITS'(1);
            end
        end else begin
            w_col_nxt = w_col_cur + ADDR_BITS'(1);
            w_row_nxt = w_row_cur;
        end
    end

    // Window shifted one column left with the new right column
    // {ram_b, ram_a, pixel} (top to bottom), plus the emit qualifiers.
    // Rows 0 and 1 of a frame are never emitted, so stale store contents from
    // an earlier or aborted frame cannot reach the output.
    always_comb begin
        w_win_nxt = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[(r*3+0)*8 +: 8] = r_win[(r*3+1)*8 +: 8];
            w_win_nxt[(r*3+1)*8 +: 8] = r_win[(r*3+2)*8 +: 8];
        end
        w_win_nxt[2*8 +: 8] = r_rd_b;
        w_win_nxt[5*8 +: 8] = r_rd_a;
        w_win_nxt[8*8 +: 8] = r_pix_d;

        w_emit = r_v1 && (r_col_d >= ADDR_BITS'(2)) && (r_row_d >= ROW_BITS'(2));
        w_last = w_emit && (r_col_d == ADDR_BITS'(IMG_W - 1))
                        && (r_row_d == ROW_BITS'(IMG_H - 1));
    end

    // Row stores: registered read at the accepted column, cascaded write one
    // cycle later at the previous column. The write address always trails
    // the read address, so the two never collide; a same-address access
    // would still return the old data because both use the same edge.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            r_rd_a <= r_ram_a[w_col_cur];
            r_rd_b <= r_ram_b[w_col_cur];
        end
        if (r_v1) begin
            r_ram_a[r_col_d] <= r_pix_d;
            r_ram_b[r_col_d] <= r_rd_a;
        end
    end

    // Raster counters and stage-1 capture of the accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= {ADDR_BITS{1'b0}};
            r_row   <= {ROW_BITS{1'b0}};
            r_v1    <= 1'b0;
            r_pix_d <= 8'h00;
            r_col_d <= {ADDR_BITS{1'b0}};
            r_row_d <= {ROW_BITS{1'b0}};
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_col   <= w_col_nxt;
                r_row   <= w_row_nxt;
                r_pix_d <= bus.in_pixel;
                r_col_d <= w_col_cur;
                r_row_d <= w_row_cur;
            end
        end
    end

    // Working window (shifts on every stage-1 pixel, borders included) and
    // the output window, which only changes when a window is emitted so that
    // out_win holds between valid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win       <= 72'h0;
            r_out_win   <= 72'h0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            r_out_last  <= w_last;
            if (r_v1) begin
                r_win <= w_win_nxt;
            end
            if (w_emit) begin
                r_out_win <= w_win_nxt;
            end
        end
    end

`ifdef WINDOW_COORD_EN
    // Centre coordinates of the emitted window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_x <= {ADDR_BITS{1'b0}};
            r_out_y <= {ROW_BITS{1'b0}};
        end else if (w_emit) begin
            r_out_x <= r_col_d - ADDR_BITS'(1);
            r_out_y <= r_row_d - ROW_BITS'(1);
        end
    end

    assign bus.out_x = r_out_x;
    assign bus.out_y = r_out_y;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_win   = r_out_win;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_window3x3_gen.sv
// ---------------------------------------------------------------------------
// tb_window3x3_gen
// Directed bench for window3x3_gen on an 8x6 frame. Expected windows are
// built from a bench-side image array as pixels are driven and queued with
// their expected arrival cycle; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_window3x3_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AB = 3;
    localparam int RB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    window3x3_gen_if
`ifdef WINDOW_COORD_EN
        #(.ADDR_BITS(AB), .ROW_BITS(RB))
`endif
        u_if ();

    window3x3_gen #(
        .IMG_W(W), .IMG_H(H), .ADDR_BITS(AB), .ROW_BITS(RB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct {
        logic [71:0] win;
        logic        last;
        int          cyc;
        int          tag;
        int          x;
        int          y;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  img [0:H-1][0:W-1];
    int          m_col = 0;
    int          m_row = 0;
    int          m_tag = 0;
    int          cnt      [0:7];
    logic [71:0] first_win[0:7];
    logic [7:0]  last_ctr [0:7];
    int          first_x  [0:7];
    int          first_y  [0:7];
    int          last_x   [0:7];
    int          last_y   [0:7];
    logic [71:0] last_seen = 72'h0;
    bit          no_consec = 1'b0;
    logic        prev_v    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard compare, hold check, gap check
    always @(negedge clk) begin
        if (rst) begin
            last_seen = 72'h0;
            prev_v    = 1'b0;
        end else begin
            if (u_if.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_window", {71'h0, u_if.out_valid}, 72'h0);
                end else begin
                    mon_e = q.pop_front();
                    check("win", u_if.out_win, mon_e.win);
                    check("last", {71'h0, u_if.out_last}, {71'h0, mon_e.last});
                    check("latency", 72'(cyc), 72'(mon_e.cyc));
`ifdef WINDOW_COORD_EN
                    check("out_x", 72'(u_if.out_x), 72'(mon_e.x));
                    check("out_y", 72'(u_if.out_y), 72'(mon_e.y));
`endif
                    if (cnt[mon_e.tag] == 0) begin
                        first_win[mon_e.tag] = u_if.out_win;
`ifdef WINDOW_COORD_EN
                        first_x[mon_e.tag] = int'(u_if.out_x);
                        first_y[mon_e.tag] = int'(u_if.out_y);
`endif
                    end
                    if (u_if.out_last === 1'b1) begin
                        last_ctr[mon_e.tag] = u_if.out_win[39:32];
`ifdef WINDOW_COORD_EN
                        last_x[mon_e.tag] = int'(u_if.out_x);
                        last_y[mon_e.tag] = int'(u_if.out_y);
`endif
                    end
                    cnt[mon_e.tag]++;
                end
                last_seen = u_if.out_win;
            end else begin
                check("hold_win", u_if.out_win, last_seen);
                check("last_low", {71'h0, u_if.out_last}, 72'h0);
            end
            if (no_consec) begin
                check("consecutive_valid", {71'h0, prev_v & u_if.out_valid}, 72'h0);
            end
            prev_v = u_if.out_valid;
        end
    end

    // Drive one pixel (aligned at posedge+1) and queue the window it completes
    task automatic drive(input logic [7:0] px, input logic sof);
        exp_t e;
        if (sof) begin
            m_col = 0;
            m_row = 0;
        end
        img[m_row][m_col] = px;
        if (m_col >= 2 && m_row >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[(r*3+c)*8 +: 8] = img[m_row-2+r][m_col-2+c];
            e.last = (m_col == W-1) && (m_row == H-1);
            e.cyc  = cyc + 2;
            e.tag  = m_tag;
            e.x    = m_col - 1;
            e.y    = m_row - 1;
            q.push_back(e);
        end
        u_if.in_valid = 1'b1;
        u_if.in_sof   = sof;
        u_if.in_pixel = px;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        u_if.in_sof   = 1'b0;
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row++;
            if (m_row == H) m_row = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            u_if.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Raster pixels up to (stop_c, stop_r) exclusive; kind 1 = inverted pattern
    task automatic frame(input int kind, input bit gap, input bit sof_first,
                         input int stop_r, input int stop_c);
        logic [7:0] px;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r > stop_r || (r == stop_r && c >= stop_c)) return;
                px = 8'((r * 16) + c);
                if (kind == 1) px = 8'hFF - px;
                drive(px, sof_first && r == 0 && c == 0);
                if (gap) idle(1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            cnt[i] = 0; first_x[i] = 0; first_y[i] = 0; last_x[i] = 0; last_y[i] = 0;
            first_win[i] = 72'h0; last_ctr[i] = 8'h00;
        end
        u_if.in_valid = 1'b0;
        u_if.in_sof   = 1'b0;
        u_if.in_pixel = 8'h00;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", {71'h0, u_if.out_valid}, 72'h0);
        check("rst_win", u_if.out_win, 72'h0);
        check("rst_last", {71'h0, u_if.out_last}, 72'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Continuous frame
        m_tag = 0;
        frame(0, 1'b0, 1'b1, H, 0);
        idle(4);
        check("f0_count", 72'(cnt[0]), 72'd24);
        check("f0_w00", {64'h0, first_win[0][7:0]}, 72'h00);
        check("f0_w11", {64'h0, first_win[0][39:32]}, 72'h11);
        check("f0_w22", {64'h0, first_win[0][71:64]}, 72'h22);
        check("f0_last_centre", {64'h0, last_ctr[0]}, 72'h46);
`ifdef WINDOW_COORD_EN
        check("f0_first_x", 72'(first_x[0]), 72'd1);
        check("f0_first_y", 72'(first_y[0]), 72'd1);
        check("f0_last_x", 72'(last_x[0]), 72'd6);
        check("f0_last_y", 72'(last_y[0]), 72'd4);
`endif

        // Same frame with in_valid low every other cycle
        m_tag = 1;
        no_consec = 1'b1;
        frame(0, 1'b1, 1'b1, H, 0);
        idle(4);
        no_consec = 1'b0;
        check("gap_count", 72'(cnt[1]), 72'd24);
        check("gap_last_centre", {64'h0, last_ctr[1]}, 72'h46);

        // Back-to-back frames, second one inverted
        m_tag = 2;
        frame(0, 1'b0, 1'b1, H, 0);
        m_tag = 3;
        frame(1, 1'b0, 1'b1, H, 0);
        idle(4);
        check("b2b_count_a", 72'(cnt[2]), 72'd24);
        check("b2b_count_b", 72'(cnt[3]), 72'd24);
        check("b2b_first_centre", {64'h0, first_win[3][39:32]}, 72'hEE);

        // Frame aborted by in_sof at (5,3), then a full frame
        m_tag = 4;
        frame(0, 1'b0, 1'b1, 3, 5);
        m_tag = 5;
        frame(1, 1'b0, 1'b1, H, 0);
        idle(4);
        check("abort_partial_count", 72'(cnt[4]), 72'd9);
        check("abort_new_count", 72'(cnt[5]), 72'd24);
        check("abort_last_centre", {64'h0, last_ctr[5]}, 72'hB9);

        // Asynchronous reset mid-row, then a frame without in_sof
        m_tag = 6;
        frame(0, 1'b0, 1'b1, 3, 4);
        idle(3);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", {71'h0, u_if.out_valid}, 72'h0);
        check("arst_win", u_if.out_win, 72'h0);
        check("arst_last", {71'h0, u_if.out_last}, 72'h0);
        #7 rst = 1'b0;
        @(posedge clk);
        #1;
        m_col = 0;
        m_row = 0;
        m_tag = 7;
        frame(1, 1'b0, 1'b0, H, 0);
        idle(4);
        check("arst_partial_count", 72'(cnt[6]), 72'd8);
        check("arst_new_count", 72'(cnt[7]), 72'd24);
        check("arst_first_centre", {64'h0, first_win[7][39:32]}, 72'hEE);
        check("arst_last_centre", {64'h0, last_ctr[7]}, 72'hB9);

        check("queue_drained", 72'(q.size()), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
- Consumes the raster pixel stream and produces a 3x3 neighbourhood window for the Sobel/edge stage.
- Owns two internal row stores that act as the reading and cascading end of the line-RAM scheme:
  - synchronous write;
  - registered 1-cycle read;
  - read-old-data on a same-address collision.
- Pixel-rate streaming with no backpressure.
- Sits between pixel capture/greyscale and the gradient kernel.

Parameters:
- IMG_W, 640, active pixels per row.
- IMG_H, 480, rows per frame.
- ADDR_BITS, 10, column counter / row-store address width; must satisfy 2^ADDR_BITS >= IMG_W.
- ROW_BITS, 9, row counter width; must satisfy 2^ROW_BITS >= IMG_H.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel present this cycle.
- in_sof  in  1  qualifies in_valid; this pixel is (0,0) of a new frame.
- in_pixel  in  8  greyscale pixel.
- out_valid  out  1  window valid this cycle.
- out_win  out  72  window. w[r][c] = out_win[(r*3+c)*8 +: 8]; r=0 oldest row, c=0 leftmost column; centre is w[1][1].
- out_last  out  1  with out_valid: centre is (IMG_W-2, IMG_H-2), the last window of the frame.

Behaviour:
- Reset:
  - Applies asynchronously on rst high.
  - out_valid=0, out_last=0, out_win=0.
  - col=0, row=0, stage-1 valid=0.
  - Row-store contents are not cleared.
- Counters advance only on in_valid:
  - col increments, wrapping at IMG_W-1 to 0.
  - On the wrap, row increments, wrapping at IMG_H-1 to 0.
- in_sof with in_valid: the pixel is forced to (0,0).
  - Counters then become col=1, row=0.
  - Legal mid-line; it aborts the partial frame.
  - If the counters were already at (0,0), there is no observable effect.
- Stage 0 (edge k, pixel accepted):
  - Both row stores read at address col.
  - Register pixel_d, col_d, row_d, v1=1.
  - ram_a holds row r-1; ram_b holds row r-2.
- Stage 1 (edge k+1, if v1):
  - Write ram_a[col_d] <= pixel_d.
  - Write ram_b[col_d] <= ram_a read data (cascade).
  - Shift the window left: column0 <= column1, column1 <= column2.
  - New column2 = {ram_b rd, ram_a rd, pixel_d}, top to bottom.
- Write/read hazards:
  - The stage-1 write address is always the previously accepted column, so there is no same-address hazard with the stage-0 read.
  - This holds at row wrap too: read 0, write IMG_W-1.
- out_valid is registered at edge k+1 = v1 && col_d>=2 && row_d>=2.
  - Latency: 2 clocks from pixel acceptance to the window containing it as bottom-right.
  - The centre is (col_d-1, row_d-1).
- Window count: exactly (IMG_W-2)*(IMG_H-2) per frame; border centres are not emitted.
- in_valid gaps:
  - Window registers hold.
  - out_valid drops for exactly the gap cycles.
  - No data loss.
- out_last = out_valid && col_d==IMG_W-1 && row_d==IMG_H-1.
- out_win holds its value when out_valid=0.
- Stale row-store data from the previous or aborted frame is never output: gating on row_d>=2 guarantees both stores have been rewritten.
- rst mid-frame: the next accepted pixel is treated as (0,0), whether or not in_sof is set.

Optional Feature:
- Macro: WINDOW_COORD_EN.
- Defined:
  - Adds ports out_x (ADDR_BITS) and out_y (ROW_BITS) = centre coordinates (col_d-1, row_d-1).
  - Registered with out_valid; reset 0; hold when not valid.
- Undefined: ports absent; behaviour otherwise identical.

Test Plan:
- IMG_W=8, IMG_H=6, continuous frame with pixel = row*16+col, in_sof on the first pixel:
  - 24 windows.
  - First window: w[0][0]=0x00, w[1][1]=0x11, w[2][2]=0x22.
  - Last window has out_last=1 and centre 0x46.
- Same frame with in_valid low every other cycle:
  - Identical 24 windows in order.
  - out_valid never high two consecutive cycles.
- Two back-to-back frames, second frame pixel = 0xFF-(row*16+col):
  - Second frame's first window centre is 0xEE.
  - No window mixes frame-1 data.
- in_sof asserted at (5,3) mid-frame, then a full frame:
  - No out_valid until the new row 2 col 2.
  - Then 24 correct windows.
- rst pulsed asynchronously (not clock-aligned) mid-row:
  - All outputs 0 immediately.
  - Next pixel without in_sof counted as (0,0); 24 windows follow.
- WINDOW_COORD_EN: continuous frame → first window out_x=1, out_y=1; last window out_x=6, out_y=4.
